ram_master: RTL
===============

Name: ram_master

Overview:
- Initiator-side controller for the 32x32 synchronous RAM (cen/wen/S_addr/S_din/S_dout interface).
- Accepts one command at a time from the system datapath (ALU/multiplier sequencer): single read, single write, block copy, block fill.
- Generates cycle-accurate RAM strobes, honours the RAM's 1-cycle registered read latency, and returns read data plus a done pulse.

Parameters:
- DATA_W, 32, RAM word width.
- ADDR_W, 5, RAM address width (32 words).
- LEN_W, 6, block length field width (legal 1..32).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command request; sampled only in IDLE.
- mode  in  2  00 read, 01 write, 10 copy, 11 fill.
- src_addr  in  ADDR_W  read/copy source start address.
- dst_addr  in  ADDR_W  write/copy/fill destination start address.
- len  in  LEN_W  word count for copy/fill.
- wdata  in  DATA_W  write/fill data.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; illegal length.
- rdata  out  DATA_W  last word read.
- cen  out  1  RAM chip enable.
- wen  out  1  RAM write enable.
- S_addr  out  ADDR_W  RAM address.
- S_din  out  DATA_W  RAM write data.
- S_dout  in  DATA_W  RAM read data, valid one cycle after a read strobe.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE. Reset mid-operation aborts immediately, leaves cen=0, and does not roll back words already written.
- All outputs are registered.
- IDLE: cen=0, wen=0. On start=1, latch mode, src_addr, dst_addr, len, wdata; clear word index i=0. start is ignored while busy.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- RD_REQ: cen=1, wen=0, S_addr=(src+i) mod 32.
- RD_WAIT: cen=0. At the edge leaving RD_WAIT, S_dout is captured into rdata. In copy mode the same edge loads S_din<=S_dout.
- WR_REQ: cen=1, wen=1, S_addr=(dst+i) mod 32, S_din per mode.
- DONE: cen=0, done=1 for exactly one cycle, then IDLE. busy stays high through DONE.
- Read (00): IDLE->RD_REQ->RD_WAIT->DONE. done is asserted 3 cycles after the start-sampling edge; rdata is valid from then on.
- Write (01): IDLE->WR_REQ(S_din=wdata)->DONE. done follows after 2 cycles.
- Copy (10): per word RD_REQ->RD_WAIT->WR_REQ, i++.
  - After word len-1, go to DONE. Total 3*len+1 cycles.
  - Forward order, read-before-write per word, so overlapping ranges give sequential forward-copy semantics.
- Fill (11): WR_REQ repeated len times with S_din=wdata, then DONE. Total len+1 cycles.
- Address wrap-around: 31+1 -> 0, no error.
- Length check (copy/fill only): len==0 or len>32 goes IDLE->DONE with err=1 and no RAM access. Read/write ignore len.
- err is 0 on all legal completions.
- rdata holds its value until the next read capture; copy leaves the last copied word in rdata.
- start coincident with DONE is ignored; start is accepted in the following IDLE cycle.

Decomposition:
- Shared include ram_master_defs.vh: state encodings, mode codes (MODE_RD, MODE_WR, MODE_CPY, MODE_FILL), MAX_LEN=32.
- No sub-module required; a single FSM plus index counter is natural.

Test Plan:
- Reset, then write mode 01, dst=5, wdata=32'hDEADBEEF -> one cycle with cen=1, wen=1, S_addr=5; done 2 cycles after start; RAM[5]=DEADBEEF.
- Read mode 00, src=5 -> cen=1, wen=0 for one cycle; done 3 cycles after start; rdata=DEADBEEF; err=0.
- Fill 11, dst=30, len=4, wdata=7 -> writes to addresses 30, 31, 0, 1 in order; done at cycle 5.
- Copy 10, src=30, dst=10, len=4, after the fill -> RAM[10..13]=7; done at cycle 13; rdata=7.
- Copy with len=0, and fill with len=33 -> done with err=1 one cycle after start; cen never asserted.
- Assert reset during a copy's WR_REQ of word 2 -> all outputs 0 immediately; words 0-1 written, remaining words unchanged; a new read succeeds afterwards.

Source files
------------

// File: rtl/ram_master_pkg.sv
// Shared types and constants for the ram_master RAM initiator.
package ram_master_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_LEN_W  = 6;
  localparam int MAX_LEN    = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_RD   = 2'b00,
    MODE_WR   = 2'b01,
    MODE_CPY  = 2'b10,
    MODE_FILL = 2'b11
  } mode_e;

  function automatic logic is_block(input mode_e m);
    return (m == MODE_CPY) || (m == MODE_FILL);
  endfunction

endpackage

// File: rtl/ram_master.sv
// Command-driven initiator for a 32x32 synchronous RAM: read, write, block copy, block fill.
// Every output is a flop; strobes for a state are computed on the transition into it.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              cen,
  output logic              wen,
  output logic [ADDR_W-1:0] S_addr,
  output logic [DATA_W-1:0] S_din,
  input  logic [DATA_W-1:0] S_dout
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;

  logic              len_bad;
  logic              last_word;
  logic [ADDR_W-1:0] cur_off;
  logic [ADDR_W-1:0] nxt_off;

  assign len_bad   = (len == '0) || (len > MAX_LEN_L);
  assign last_word = !is_block(mode_q) || (idx_q == len_q - LEN_W'(1));
  // Offsets are ADDR_W wide so src/dst + offset wraps modulo the RAM depth.
  assign cur_off   = idx_q[ADDR_W-1:0];
  assign nxt_off   = idx_q[ADDR_W-1:0] + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    cen_d   = 1'b0;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          wdata_d = wdata;
          idx_d   = '0;
          if (is_block(mode_e'(mode)) && len_bad) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (mode_e'(mode) == MODE_RD || mode_e'(mode) == MODE_CPY) begin
            state_d = ST_RD_REQ;
            cen_d   = 1'b1;
            addr_d  = src_addr;
          end else begin
            state_d = ST_WR_REQ;
            cen_d   = 1'b1;
            wen_d   = 1'b1;
            addr_d  = dst_addr;
            din_d   = wdata;
          end
        end
      end

      ST_RD_REQ: state_d = ST_RD_WAIT;

      ST_RD_WAIT: begin
        rdata_d = S_dout;
        if (mode_q == MODE_CPY) begin
          state_d = ST_WR_REQ;
          cen_d   = 1'b1;
          wen_d   = 1'b1;
          addr_d  = dst_q + cur_off;
          din_d   = S_dout;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_WR_REQ: begin
        if (last_word) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + LEN_W'(1);
          cen_d = 1'b1;
          if (mode_q == MODE_CPY) begin
            state_d = ST_RD_REQ;
            addr_d  = src_q + nxt_off;
          end else begin
            state_d = ST_WR_REQ;
            wen_d   = 1'b1;
            addr_d  = dst_q + nxt_off;
            din_d   = wdata_q;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_RD;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cen_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign cen    = cen_q;
  assign wen    = wen_q;
  assign S_addr = addr_q;
  assign S_din  = din_q;

endmodule
